pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencer for the Core101 five-stage core. It drives the set (enable) and flush (synchronous clear) controls of the IFU PC/IR registers and the IF/ID, ID/IS and IS/EX pipeline registers. It sequences four conditions: post-reset boot, branch-misprediction flush from the BRU, multi-cycle LSU stalls, and load-use hazards. It also handles instruction-memory wait states, and optionally collects performance counts.

## Interface
- BOOT_CYCLES, 4: idle cycles after reset before fetch starts (1..255).
- STALL_MAX, 15: maximum consecutive STALL cycles before watchdog trips (1..255).

- clock_in  in  1  core clock.
- reset_in  in  1  synchronous, active-high reset.
- imem_ready_in  in  1  ins_mem_data_in valid this cycle.
- bru_flush_in  in  1  BRU misprediction/redirect, from EX.
- lsu_busy_in  in  1  LSU multi-cycle op occupying EX.
- is_load_in  in  1  instruction in IS is a load.
- is_rd_addr_in  in  5  RD of instruction in IS.
- id_rs1_addr_in  in  5  RS1 of instruction in ID.
- id_rs2_addr_in  in  5  RS2 of instruction in ID.
- ifu_pc_set_out  out  1  PC register enable.
- ifu_ir_set_out  out  1  IR register enable.
- if_id_set_out, id_is_set_out, is_ex_set_out  out  1 each  pipeline register enables.
- if_id_flush_out, id_is_flush_out, is_ex_flush_out  out  1 each  synchronous clear (bubble insert); flush wins over set in the target register.
- stall_timeout_out  out  1  sticky watchdog flag.
- state_out  out  2  BOOT=0, RUN=1, FLUSH=2, STALL=3.
- perf_stall_cycles_out  out  16  saturating stall-cycle count.
- perf_flush_count_out  out  16  saturating flush-event count.

## Operation
- State register and counters are sequential. All control outputs are combinational from the current state and inputs (Mealy).
- **BOOT**
  - All set outputs 0; all flush outputs 1.
  - An 8-bit boot counter counts up to BOOT_CYCLES-1, then the FSM moves to RUN.
- **RUN, priority order**
  - 1. bru_flush_in: pc_set=1 (IFU loads redirect target); ir_set=0; if_id, id_is, is_ex flush=1. Next state FLUSH.
  - 2. lsu_busy_in: all sets 0, no flushes. Next state STALL; stall counter loads 1.
  - 3. Load-use hazard: is_load_in && is_rd_addr_in!=0 && is_rd_addr_in matches id_rs1_addr_in or id_rs2_addr_in.
    - pc, ir, if_id and id_is set=0; is_ex_flush=1.
    - Stays in RUN; lasts exactly one cycle because the load advances.
  - 4. !imem_ready_in: pc_set=ir_set=0; if_id_flush=1; id_is and is_ex set=1, so downstream drains.
  - 5. Otherwise all sets 1, all flushes 0.
- **FLUSH**
  - if_id_flush=1 and pc_set=ir_set=0 until imem_ready_in.
  - On imem_ready_in: ir_set=1, pc_set=1, next state RUN.
  - id_is and is_ex set=1 (they are already bubbles).
  - bru_flush_in in FLUSH is ignored: the EX stage holds a bubble.
- **STALL**
  - All sets 0. Stall counter increments each cycle.
  - lsu_busy_in low: next state RUN.
  - Counter reaches STALL_MAX while busy is still high: stall_timeout_out set (sticky until reset), next state RUN.
  - bru_flush_in is not sampled in STALL.
- Simultaneous bru_flush_in and lsu_busy_in in RUN: flush wins, and is_ex_flush kills the LSU op.
- reset_in asserted in any state: next cycle is BOOT with counters cleared, so a mid-stall or mid-flush reset aborts cleanly.

## Timing
- Reset values:
  - state_out=0 (BOOT).
  - All sets 0, all flushes 1.
  - stall_timeout_out=0; perf counters 0.
- First fetch enable (pc_set=1) occurs BOOT_CYCLES cycles after the cycle reset_in deasserts.
- Flush penalty: the cycle bru_flush_in is seen, plus FLUSH cycles until imem_ready_in. The minimum is 2 cycles.
- Load-use penalty is 1 cycle. LSU stall penalty equals the number of busy cycles, capped at STALL_MAX.
- Perf counters update on the clock edge following the event. They saturate at 16'hFFFF.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cycles_out increments every cycle spent in STALL or on a load-use bubble.
  - perf_flush_count_out increments once per accepted bru_flush_in.
- Undefined: both perf outputs are tied to 0 and no counter flops are synthesized. Ports remain present.

## Test plan
- Reset, then release with BOOT_CYCLES=4 and imem_ready_in=1 -> state_out=0 for 4 cycles, all flushes 1, then state_out=1 with all sets 1.
- In RUN, pulse bru_flush_in for 1 cycle with imem_ready_in low for 2 cycles -> all flushes 1 in the pulse cycle; FLUSH for 3 cycles with if_id_flush=1; RUN resumes. perf_flush_count_out=1 when PIPE_CTRL_PERF_EN is defined.
- is_load_in=1, is_rd_addr_in=5, id_rs2_addr_in=5 -> exactly one cycle of is_ex_flush=1 with pc/if_id/id_is set=0. Repeating with rd=0 gives no bubble.
- lsu_busy_in high for 3 cycles -> state_out=3 for 3 cycles with all sets 0, then RUN; stall_timeout_out stays 0.
- lsu_busy_in held high with STALL_MAX=15 -> stall_timeout_out rises after 15 STALL cycles, state returns to RUN, and the flag stays 1 until reset.
- bru_flush_in and lsu_busy_in asserted together, then reset_in asserted during FLUSH -> flush taken (not stall); the next cycle after reset shows state_out=0 with the boot counter restarted.

Source files
------------

// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline sequencer for the Core101 five-stage core. Drives the enable ("set")
// and synchronous-clear ("flush") controls of the IFU PC/IR registers and of
// the IF/ID, ID/IS and IS/EX pipeline registers. It sequences post-reset boot,
// BRU redirect flushes, multi-cycle LSU stalls (with a watchdog), load-use
// bubbles and instruction-memory wait states. In every target register a
// flush overrides a set.
//
// State register and counters are sequential; all control outputs are Mealy
// (combinational from the current state and the inputs).
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   : saturating 16-bit stall-cycle and flush-event counters.
//   undefined : perf outputs are tied to zero and no counter flops exist.
//
// Parameters
//   BOOT_CYCLES  idle cycles after reset before fetch starts (1..255)
//   STALL_MAX    consecutive STALL cycles before the watchdog trips (1..255)
//
// Ports
//   clock_in              in   core clock
//   reset_in              in   synchronous, active-high reset
//   imem_ready_in         in   instruction memory data valid this cycle
//   bru_flush_in          in   BRU misprediction/redirect (from EX)
//   lsu_busy_in           in   LSU multi-cycle op occupying EX
//   is_load_in            in   instruction in IS is a load
//   is_rd_addr_in[4:0]    in   destination register of instruction in IS
//   id_rs1_addr_in[4:0]   in   source register 1 of instruction in ID
//   id_rs2_addr_in[4:0]   in   source register 2 of instruction in ID
//   ifu_pc_set_out        out  PC register enable
//   ifu_ir_set_out        out  IR register enable
//   if_id_set_out         out  IF/ID register enable
//   id_is_set_out         out  ID/IS register enable
//   is_ex_set_out         out  IS/EX register enable
//   if_id_flush_out       out  IF/ID synchronous clear (bubble insert)
//   id_is_flush_out       out  ID/IS synchronous clear
//   is_ex_flush_out       out  IS/EX synchronous clear
//   stall_timeout_out     out  sticky LSU stall watchdog flag
//   state_out[1:0]        out  BOOT=0, RUN=1, FLUSH=2, STALL=3
//   perf_stall_cycles_out out  saturating stall/bubble cycle count
//   perf_flush_count_out  out  saturating accepted-flush count
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned STALL_MAX   = 15
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        imem_ready_in,
    input  logic        bru_flush_in,
    input  logic        lsu_busy_in,
    input  logic        is_load_in,
    input  logic [4:0]  is_rd_addr_in,
    input  logic [4:0]  id_rs1_addr_in,
    input  logic [4:0]  id_rs2_addr_in,
    output logic        ifu_pc_set_out,
    output logic        ifu_ir_set_out,
    output logic        if_id_set_out,
    output logic        id_is_set_out,
    output logic        is_ex_set_out,
    output logic        if_id_flush_out,
    output logic        id_is_flush_out,
    output logic        is_ex_flush_out,
    output logic        stall_timeout_out,
    output logic [1:0]  state_out,
    output logic [15:0] perf_stall_cycles_out,
    output logic [15:0] perf_flush_count_out
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_boot_cnt;
    logic [7:0] w_boot_cnt_nxt;
    logic [7:0] r_stall_cnt;
    logic [7:0] w_stall_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       w_hazard;

    // Load-use hazard: the load in IS writes a register that the instruction
    // in ID reads. x0 is never a real dependency.
    assign w_hazard = is_load_in
                      && (is_rd_addr_in != 5'd0)
                      && ((is_rd_addr_in == id_rs1_addr_in)
                          || (is_rd_addr_in == id_rs2_addr_in));

    // ---- state / counter register stage ----
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= 8'd0;
            r_stall_cnt <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_boot_cnt  <= w_boot_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_nxt     = r_state;
        w_boot_cnt_nxt  = r_boot_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_timeout_nxt   = r_timeout;
        unique case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt >= BOOT_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + 8'd1;
                end
            end
            ST_RUN: begin
                // A redirect beats an LSU op: the flush kills it in IS/EX.
                if (bru_flush_in) begin
                    w_state_nxt = ST_FLUSH;
                end else if (lsu_busy_in) begin
                    w_state_nxt     = ST_STALL;
                    w_stall_cnt_nxt = 8'd1;
                end
            end
            ST_FLUSH: begin
                if (imem_ready_in) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STALL: begin
                if (!lsu_busy_in) begin
                    w_state_nxt = ST_RUN;
                end else if (r_stall_cnt >= STALL_LAST) begin
                    // Watchdog: give up on the LSU, remember it happened.
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Mealy control outputs
    always_comb begin
        ifu_pc_set_out  = 1'b0;
        ifu_ir_set_out  = 1'b0;
        if_id_set_out   = 1'b0;
        id_is_set_out   = 1'b0;
        is_ex_set_out   = 1'b0;
        if_id_flush_out = 1'b0;
        id_is_flush_out = 1'b0;
        is_ex_flush_out = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                if_id_flush_out = 1'b1;
                id_is_flush_out = 1'b1;
                is_ex_flush_out = 1'b1;
            end
            ST_RUN: begin
                if (bru_flush_in) begin
                    // PC takes the redirect target; everything younger dies.
                    ifu_pc_set_out  = 1'b1;
                    if_id_flush_out = 1'b1;
                    id_is_flush_out = 1'b1;
                    is_ex_flush_out = 1'b1;
                end else if (lsu_busy_in) begin
                    // Freeze everything while the LSU owns EX.
                end else if (w_hazard) begin
                    // Hold the front end; the load advances and a bubble
                    // enters EX, so this lasts one cycle.
                    is_ex_flush_out = 1'b1;
                end else if (!imem_ready_in) begin
                    // Fetch waits; a bubble enters ID while downstream drains.
                    if_id_flush_out = 1'b1;
                    id_is_set_out   = 1'b1;
                    is_ex_set_out   = 1'b1;
                end else begin
                    ifu_pc_set_out = 1'b1;
                    ifu_ir_set_out = 1'b1;
                    if_id_set_out  = 1'b1;
                    id_is_set_out  = 1'b1;
                    is_ex_set_out  = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Downstream already holds bubbles and may advance freely.
                // IF/ID keeps inserting bubbles until the redirected
                // instruction has been captured in IR.
                if_id_flush_out = 1'b1;
                id_is_set_out   = 1'b1;
                is_ex_set_out   = 1'b1;
                if (imem_ready_in) begin
                    ifu_pc_set_out = 1'b1;
                    ifu_ir_set_out = 1'b1;
                end
            end
            ST_STALL: begin
                // All enables low, no flushes.
            end
            default: begin
                if_id_flush_out = 1'b1;
                id_is_flush_out = 1'b1;
                is_ex_flush_out = 1'b1;
            end
        endcase
    end

    assign state_out         = r_state;
    assign stall_timeout_out = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;
    logic        w_bubble;
    logic        w_flush_take;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only count events that actually won the RUN priority chain.
    assign w_bubble     = (r_state == ST_RUN) && !bru_flush_in
                          && !lsu_busy_in && w_hazard;
    assign w_flush_take = (r_state == ST_RUN) && bru_flush_in;

    // ---- performance counter stage ----
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_perf_stall <= 16'd0;
            r_perf_flush <= 16'd0;
        end else begin
            if ((r_state == ST_STALL) || w_bubble) begin
                r_perf_stall <= sat_inc16(r_perf_stall);
            end
            if (w_flush_take) begin
                r_perf_flush <= sat_inc16(r_perf_flush);
            end
        end
    end

    assign perf_stall_cycles_out = r_perf_stall;
    assign perf_flush_count_out  = r_perf_flush;
`else
    assign perf_stall_cycles_out = 16'd0;
    assign perf_flush_count_out  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_in;
    logic        imem_ready_in;
    logic        bru_flush_in;
    logic        lsu_busy_in;
    logic        is_load_in;
    logic [4:0]  is_rd_addr_in;
    logic [4:0]  id_rs1_addr_in;
    logic [4:0]  id_rs2_addr_in;
    logic        ifu_pc_set_out;
    logic        ifu_ir_set_out;
    logic        if_id_set_out;
    logic        id_is_set_out;
    logic        is_ex_set_out;
    logic        if_id_flush_out;
    logic        id_is_flush_out;
    logic        is_ex_flush_out;
    logic        stall_timeout_out;
    logic [1:0]  state_out;
    logic [15:0] perf_stall_cycles_out;
    logic [15:0] perf_flush_count_out;

    logic [7:0]  ctl;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .BOOT_CYCLES (4),
        .STALL_MAX   (15)
    ) dut (
        .clock_in              (clk),
        .reset_in              (reset_in),
        .imem_ready_in         (imem_ready_in),
        .bru_flush_in          (bru_flush_in),
        .lsu_busy_in           (lsu_busy_in),
        .is_load_in            (is_load_in),
        .is_rd_addr_in         (is_rd_addr_in),
        .id_rs1_addr_in        (id_rs1_addr_in),
        .id_rs2_addr_in        (id_rs2_addr_in),
        .ifu_pc_set_out        (ifu_pc_set_out),
        .ifu_ir_set_out        (ifu_ir_set_out),
        .if_id_set_out         (if_id_set_out),
        .id_is_set_out         (id_is_set_out),
        .is_ex_set_out         (is_ex_set_out),
        .if_id_flush_out       (if_id_flush_out),
        .id_is_flush_out       (id_is_flush_out),
        .is_ex_flush_out       (is_ex_flush_out),
        .stall_timeout_out     (stall_timeout_out),
        .state_out             (state_out),
        .perf_stall_cycles_out (perf_stall_cycles_out),
        .perf_flush_count_out  (perf_flush_count_out)
    );

    // {pc, ir, if_id_set, id_is_set, is_ex_set, if_id_flush, id_is_flush, is_ex_flush}
    assign ctl = {ifu_pc_set_out, ifu_ir_set_out, if_id_set_out, id_is_set_out,
                  is_ex_set_out, if_id_flush_out, id_is_flush_out, is_ex_flush_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait to the falling edge, then check state and control vector.
    task automatic cyc(input string tag, input logic [1:0] st, input logic [7:0] c);
        @(negedge clk);
        chk({tag, "_state"}, 32'(state_out), 32'(st));
        chk({tag, "_ctl"}, 32'(ctl), 32'(c));
    endtask

    task automatic chk_perf(input string tag, input int stalls, input int flushes);
        chk({tag, "_pstall"}, 32'(perf_stall_cycles_out), PERF ? 32'(stalls) : 32'd0);
        chk({tag, "_pflush"}, 32'(perf_flush_count_out), PERF ? 32'(flushes) : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_in       = 1'b1;
        imem_ready_in  = 1'b1;
        bru_flush_in   = 1'b0;
        lsu_busy_in    = 1'b0;
        is_load_in     = 1'b0;
        is_rd_addr_in  = 5'd0;
        id_rs1_addr_in = 5'd0;
        id_rs2_addr_in = 5'd0;
        tick();
        tick();

        // Reset state
        cyc("rst", 2'd0, 8'h07);
        chk("rst_timeout", 32'(stall_timeout_out), 32'd0);
        chk_perf("rst", 0, 0);
        tick();
        reset_in = 1'b0;

        // Boot: four idle cycles, then fetch
        for (int i = 0; i < 4; i++) begin
            cyc("boot", 2'd0, 8'h07);
            tick();
        end
        cyc("run0", 2'd1, 8'hF8);
        tick();

        // Branch flush with two imem wait cycles; bru in FLUSH ignored
        bru_flush_in = 1'b1;
        cyc("bru", 2'd1, 8'h87);
        tick();
        bru_flush_in  = 1'b0;
        imem_ready_in = 1'b0;
        cyc("fl1", 2'd2, 8'h1C);
        chk_perf("fl1", 0, 1);
        tick();
        bru_flush_in = 1'b1;
        cyc("fl2", 2'd2, 8'h1C);
        tick();
        bru_flush_in  = 1'b0;
        imem_ready_in = 1'b1;
        cyc("fl3", 2'd2, 8'hDC);
        tick();
        cyc("fl_run", 2'd1, 8'hF8);
        chk_perf("fl_run", 0, 1);
        tick();

        // Load-use hazards
        is_load_in     = 1'b1;
        is_rd_addr_in  = 5'd5;
        id_rs2_addr_in = 5'd5;
        cyc("lu_rs2", 2'd1, 8'h01);
        tick();
        is_load_in = 1'b0;
        cyc("lu_done", 2'd1, 8'hF8);
        chk_perf("lu_done", 1, 1);
        tick();
        is_load_in     = 1'b1;
        is_rd_addr_in  = 5'd0;
        id_rs1_addr_in = 5'd0;
        id_rs2_addr_in = 5'd0;
        cyc("lu_rd0", 2'd1, 8'hF8);
        tick();
        is_rd_addr_in  = 5'd7;
        id_rs1_addr_in = 5'd3;
        id_rs2_addr_in = 5'd4;
        cyc("lu_nomatch", 2'd1, 8'hF8);
        tick();
        id_rs1_addr_in = 5'd7;
        cyc("lu_rs1", 2'd1, 8'h01);
        tick();

        // Imem wait in RUN
        is_load_in    = 1'b0;
        imem_ready_in = 1'b0;
        cyc("imem_wait", 2'd1, 8'h1C);
        tick();
        imem_ready_in = 1'b1;

        // LSU stall for 3 busy cycles; busy beats a simultaneous hazard
        lsu_busy_in = 1'b1;
        is_load_in  = 1'b1;
        cyc("st_run", 2'd1, 8'h00);
        tick();
        is_load_in = 1'b0;
        cyc("st1", 2'd3, 8'h00);
        tick();
        cyc("st2", 2'd3, 8'h00);
        tick();
        lsu_busy_in = 1'b0;
        cyc("st3", 2'd3, 8'h00);
        chk("st3_timeout", 32'(stall_timeout_out), 32'd0);
        tick();
        cyc("st_end", 2'd1, 8'hF8);
        chk("st_end_timeout", 32'(stall_timeout_out), 32'd0);
        chk_perf("st_end", 5, 1);
        tick();

        // Watchdog: busy held through 15 STALL cycles
        lsu_busy_in = 1'b1;
        cyc("wd_run", 2'd1, 8'h00);
        tick();
        for (int k = 1; k <= 15; k++) begin
            cyc("wd_stall", 2'd3, 8'h00);
            chk("wd_flag_low", 32'(stall_timeout_out), 32'd0);
            tick();
        end
        cyc("wd_trip", 2'd1, 8'h00);
        chk("wd_flag_set", 32'(stall_timeout_out), 32'd1);
        tick();
        lsu_busy_in = 1'b0;
        cyc("wd_back", 2'd3, 8'h00);
        chk("wd_sticky1", 32'(stall_timeout_out), 32'd1);
        tick();
        cyc("wd_run2", 2'd1, 8'hF8);
        chk("wd_sticky2", 32'(stall_timeout_out), 32'd1);
        chk_perf("wd_run2", 21, 1);
        tick();

        // Flush and busy together: flush wins; then reset during FLUSH
        bru_flush_in = 1'b1;
        lsu_busy_in  = 1'b1;
        cyc("bb", 2'd1, 8'h87);
        tick();
        bru_flush_in  = 1'b0;
        lsu_busy_in   = 1'b0;
        imem_ready_in = 1'b0;
        cyc("bb_fl", 2'd2, 8'h1C);
        chk_perf("bb_fl", 21, 2);
        tick();
        reset_in = 1'b1;
        cyc("rst_fl", 2'd2, 8'h1C);
        tick();
        reset_in      = 1'b0;
        imem_ready_in = 1'b1;
        cyc("reboot0", 2'd0, 8'h07);
        chk("reboot_timeout", 32'(stall_timeout_out), 32'd0);
        chk_perf("reboot", 0, 0);
        tick();
        for (int i = 1; i < 4; i++) begin
            cyc("reboot", 2'd0, 8'h07);
            tick();
        end
        cyc("reboot_run", 2'd1, 8'hF8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
